// File: rtl/mult_pipe_wrap.sv
// Registered valid/ready I/O stage around the combinational 127x127 multiplier `mult`.
// Optional behavioural self-check of the multiplier enabled by macro MULT_PIPE_SELFCHECK_EN.

module mult (
  input  logic [126:0] IN1,
  input  logic [126:0] IN2,
  output logic [253:0] OUTPUT
);

  assign OUTPUT = {127'd0, IN1} * {127'd0, IN2};

endmodule

module mult_pipe_wrap #(
  parameter int SETTLE_CYCLES = 4,
  parameter int W             = 127
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           err_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [2*W-1:0]   mult_out;

  mult u_mult (
    .IN1    (op_a),
    .IN2    (op_b),
    .OUTPUT (mult_out)
  );

  // DONE forwards out_ready so a product hand-off and a new accept share one edge.
  always_comb begin
    in_ready = 1'b0;
    if (rst) begin
      in_ready = 1'b0;
    end else begin
      case (state)
        IDLE:    in_ready = 1'b1;
        DONE:    in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

`ifdef MULT_PIPE_SELFCHECK_EN
  logic [2*W-1:0] ref_p;
  logic           err_r;

  assign ref_p    = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
  assign err_flag = err_r;

  // Sticky flag raised when the multiplier disagrees with the reference at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if ((state == BUSY) && (cnt == 4'd0) && (mult_out != ref_p)) begin
      err_r <= 1'b1;
    end
  end
`else
  assign err_flag = 1'b0;
`endif

  // Handshake FSM: operands stay frozen on mult through BUSY and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_a      <= '0;
      op_b      <= '0;
      out_p     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a  <= in_a;
            op_b  <= in_b;
            cnt   <= 4'(SETTLE_CYCLES - 1);
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            out_p     <= mult_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              op_a  <= in_a;
              op_b  <= in_b;
              cnt   <= 4'(SETTLE_CYCLES - 1);
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_pipe_wrap.sv
// Self-checking bench for mult_pipe_wrap: directed scenarios plus a randomized
// stream checked against an arithmetic reference queue.

module tb_mult_pipe_wrap;

  localparam int SETTLE = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [126:0] in_a;
  logic [126:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [253:0] out_p;
  logic         err_flag;

  int errors;
  int checks;

  mult_pipe_wrap #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .err_flag  (err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [253:0] prod(input logic [126:0] a, input logic [126:0] b);
    logic [253:0] r;
    r = {127'd0, a} * {127'd0, b};
    return r;
  endfunction

  function automatic logic [126:0] rand127();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[126:0];
  endfunction

  // Offer a pair, wait for accept, then wait for out_valid; no checking here.
  task automatic run_one(input logic [126:0] a, input logic [126:0] b,
                         output int n, output bit to, output logic [253:0] p);
    int k;
    k = 0;
    in_a = a; in_b = b; in_valid = 1'b1;
    #1;
    while (!in_ready && k < 50) begin step(); k++; end
    to = !in_ready;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin step(); n++; end
    if (!out_valid) to = 1'b1;
    p = out_p;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_p !== 254'd0) begin errors++; $display("FAIL reset_out_p: got %0h want 0", out_p); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_flag); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int n; bit to; logic [253:0] p;
    out_ready = 1'b1;
    run_one(127'd3, 127'd5, n, to, p);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout: got timeout want completion"); end
    checks++; if (n !== SETTLE) begin errors++; $display("FAIL basic_latency: got %0d want %0d", n, SETTLE); end
    checks++; if (p !== 254'd15) begin errors++; $display("FAIL basic_product: got %0d want 15", p); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL basic_err: got %b want 0", err_flag); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got out_valid %b want 0", out_valid); end
  endtask

  task automatic test_corner();
    logic [126:0] ta [4];
    logic [126:0] tb [4];
    logic [253:0] te [4];
    logic [126:0] ones;
    logic [126:0] p126;
    int n; bit to; logic [253:0] p;
    ones = '1;
    p126 = 127'd1 << 126;
    ta[0] = ones;  tb[0] = ones;   te[0] = 254'd0 - (254'd1 << 128) + 254'd1;
    ta[1] = 127'd0; tb[1] = rand127(); te[1] = 254'd0;
    ta[2] = 127'd1; tb[2] = p126;  te[2] = 254'd1 << 126;
    ta[3] = ones;  tb[3] = 127'd2; te[3] = (254'd1 << 128) - 254'd2;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_one(ta[i], tb[i], n, to, p);
      checks++; if (to || n !== SETTLE) begin errors++; $display("FAIL corner%0d_latency: got %0d (timeout %b) want %0d", i, n, to, SETTLE); end
      checks++; if (p !== te[i]) begin errors++; $display("FAIL corner%0d_product: got %0h want %0h", i, p, te[i]); end
      step();
    end
  endtask

  task automatic test_backpressure();
    int n; bit to; logic [253:0] p, e;
    logic [126:0] a, b;
    a = rand127(); b = rand127(); e = prod(a, b);
    out_ready = 1'b0;
    run_one(a, b, n, to, p);
    checks++; if (to || p !== e) begin errors++; $display("FAIL bp_product: got %0h want %0h", p, e); end
    in_valid = 1'b1; in_a = 127'd11; in_b = 127'd13;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (out_p !== e || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got p=%0h v=%b r=%b want p=%0h v=1 r=0", i, out_p, out_valid, in_ready, e);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [126:0] pa [3];
    logic [126:0] pb [3];
    logic [253:0] pe [3];
    int t [3];
    int idx, got;
    bit acc;
    pa[0] = 127'd7;  pb[0] = 127'd9;  pe[0] = 254'd63;
    pa[1] = 127'd1 << 100; pb[1] = 127'd3; pe[1] = 254'd3 << 100;
    pa[2] = 127'd123456789; pb[2] = 127'd987654321; pe[2] = 254'd121932631112635269;
    idx = 0; got = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_a = pa[0]; in_b = pb[0];
    #1;
    for (int c = 0; c < 60 && got < 3; c++) begin
      acc = in_valid && in_ready;
      step();
      if (acc) begin
        idx++;
        if (idx < 3) begin in_a = pa[idx]; in_b = pb[idx]; end
        else in_valid = 1'b0;
      end
      if (out_valid) begin
        checks++; if (out_p !== pe[got]) begin errors++; $display("FAIL b2b_product%0d: got %0h want %0h", got, out_p, pe[got]); end
        t[got] = c;
        got++;
      end
      #1;
    end
    in_valid = 1'b0;
    checks++; if (got !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", got); end
    if (got == 3) begin
      checks++; if (t[1] - t[0] !== SETTLE + 1) begin errors++; $display("FAIL b2b_spacing1: got %0d want %0d", t[1] - t[0], SETTLE + 1); end
      checks++; if (t[2] - t[1] !== SETTLE + 1) begin errors++; $display("FAIL b2b_spacing2: got %0d want %0d", t[2] - t[1], SETTLE + 1); end
    end
    step();
  endtask

  task automatic test_reset_mid_busy();
    int n; bit to; logic [253:0] p;
    out_ready = 1'b1;
    in_a = 127'd9; in_b = 127'd9; in_valid = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_valid: got %b want 0", out_valid); end
    checks++; if (out_p !== 254'd0) begin errors++; $display("FAIL rst_busy_out_p: got %0h want 0", out_p); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_busy_idle: got in_ready %b want 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_busy_discard: got out_valid %b want 0", out_valid); end
    run_one(127'd4, 127'd4, n, to, p);
    checks++; if (to || n !== SETTLE) begin errors++; $display("FAIL rst_busy_latency: got %0d want %0d", n, SETTLE); end
    checks++; if (p !== 254'd16) begin errors++; $display("FAIL rst_busy_product: got %0d want 16", p); end
    step();
  endtask

  task automatic test_random();
    logic [253:0] q [$];
    logic [253:0] held, e;
    logic [126:0] ca, cb;
    bit acc, del, hold_chk;
    int delivered;
    delivered = 0; hold_chk = 1'b0; held = '0;
    ca = rand127(); cb = rand127();
    for (int c = 0; c < 40000 && delivered < 2000; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a = ca; in_b = cb;
      #1;
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (hold_chk) begin
        checks++;
        if (out_valid !== 1'b1 || out_p !== held) begin
          errors++; $display("FAIL rand_hold: got v=%b p=%0h want v=1 p=%0h", out_valid, out_p, held);
        end
      end
      hold_chk = out_valid && !out_ready;
      held = out_p;
      if (del) begin
        e = (q.size() > 0) ? q.pop_front() : '1;
        checks++;
        if (out_p !== e) begin errors++; $display("FAIL rand_product%0d: got %0h want %0h", delivered, out_p, e); end
        delivered++;
      end
      if (acc) q.push_back(prod(ca, cb));
      step();
      if (acc) begin
        case ($urandom_range(0, 9))
          0:       begin ca = '1; cb = rand127(); end
          1:       begin ca = 127'd0; cb = rand127(); end
          default: begin ca = rand127(); cb = rand127(); end
        endcase
      end
      checks++;
      if (err_flag !== 1'b0) begin errors++; $display("FAIL rand_err_flag: got %b want 0", err_flag); end
    end
    checks++; if (delivered !== 2000) begin errors++; $display("FAIL rand_count: got %0d want 2000", delivered); end
    in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    test_reset();
    test_basic();
    test_corner();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
